// File: rtl/jzjpcc_sram_dp_if.sv
// jzjpcc_sram_dp_if: dual-port SRAM access bundle, both ports plus status
interface jzjpcc_sram_dp_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int BYTES = 4
);
  localparam int DW = 8 * BYTES;
  logic ready;
  logic collision;
  logic [ADDR_WIDTH-1:0] addressA, addressB;
  logic [DW-1:0] writeDataA, writeDataB;
  logic writeEnableA, writeEnableB;
  logic [BYTES-1:0] byteWriteMaskA, byteWriteMaskB;
  logic [DW-1:0] readA, readB;
  modport master (
    output addressA, addressB, writeDataA, writeDataB, writeEnableA, writeEnableB,
           byteWriteMaskA, byteWriteMaskB,
    input  ready, collision, readA, readB
  );
  modport slave (
    input  addressA, addressB, writeDataA, writeDataB, writeEnableA, writeEnableB,
           byteWriteMaskA, byteWriteMaskB,
    output ready, collision, readA, readB
  );
endinterface

// File: rtl/jzjpcc_sram_dp.sv
// jzjpcc_sram_dp: true dual-port byte-masked SRAM with post-reset clear walk
module jzjpcc_sram_dp #(
  parameter int ADDR_WIDTH = 12,
  parameter int BYTES = 4,
  parameter int WRITE_FIRST = 0,
  parameter int OUT_REG = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clock,
  input logic reset,
  jzjpcc_sram_dp_if.slave bus
);
  localparam int DW = 8 * BYTES;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] merged_a, merged_b, q_a, q_b, p_a, p_b;
  logic live, coll;
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic we, input logic [BYTES-1:0] m);
    merge = old;
    for (int i = 0; i < BYTES; i++)
      if (we && m[i]) merge[8*i +: 8] = wd[8*i +: 8];
  endfunction
  assign live = state == READY;
  always_comb begin
    state_nx = state;
    merged_a = merge(mem[bus.addressA], bus.writeDataA, bus.writeEnableA, bus.byteWriteMaskA);
    merged_b = merge(mem[bus.addressB], bus.writeDataB, bus.writeEnableB, bus.byteWriteMaskB);
    state_nx = (state == RESET) ? ((CLEAR_ON_RESET != 0) ? CLEAR : READY)
             : (state == CLEAR && cnt == '1) ? READY : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RESET;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
  // B is written before A so that A wins bytes enabled on both ports
  always_ff @(posedge clock) begin
    if (state == CLEAR) mem[cnt] <= '0;
    for (int i = 0; i < BYTES; i++) begin
      if (live && bus.writeEnableB && bus.byteWriteMaskB[i])
        mem[bus.addressB][8*i +: 8] <= bus.writeDataB[8*i +: 8];
      if (live && bus.writeEnableA && bus.byteWriteMaskA[i])
        mem[bus.addressA][8*i +: 8] <= bus.writeDataA[8*i +: 8];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      q_a <= '0;
      q_b <= '0;
      p_a <= '0;
      p_b <= '0;
      coll <= 1'b0;
    end else begin
      q_a <= !live ? '0 : (WRITE_FIRST != 0) ? merged_a : mem[bus.addressA];
      q_b <= !live ? '0 : (WRITE_FIRST != 0) ? merged_b : mem[bus.addressB];
      p_a <= q_a;
      p_b <= q_b;
      coll <= live && bus.writeEnableA && bus.writeEnableB && bus.addressA == bus.addressB
              && |(bus.byteWriteMaskA & bus.byteWriteMaskB);
    end
  end
  assign bus.ready = live;
  assign bus.collision = coll;
  assign bus.readA = (OUT_REG != 0) ? p_a : q_a;
  assign bus.readB = (OUT_REG != 0) ? p_b : q_b;
endmodule

// File: tb/tb_jzjpcc_sram_dp.sv
// tb_jzjpcc_sram_dp: scoreboard bench over two configurations of the SRAM
module tb_jzjpcc_sram_dp;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst0 = 1, rst1 = 1;
  int cyc = 0, checks = 0, failures = 0;
  always @(posedge clk) cyc <= cyc + 1;

  jzjpcc_sram_dp_if #(.ADDR_WIDTH(4), .BYTES(4)) b0 ();
  jzjpcc_sram_dp_if #(.ADDR_WIDTH(4), .BYTES(4)) b1 ();
  jzjpcc_sram_dp #(.ADDR_WIDTH(4), .BYTES(4), .WRITE_FIRST(0), .OUT_REG(0), .CLEAR_ON_RESET(1))
    u0 (.clock(clk), .reset(rst0), .bus(b0));
  jzjpcc_sram_dp #(.ADDR_WIDTH(4), .BYTES(4), .WRITE_FIRST(1), .OUT_REG(1), .CLEAR_ON_RESET(0))
    u1 (.clock(clk), .reset(rst1), .bus(b1));

  typedef struct {int d; int p; int due; string tag; logic [31:0] v;} ent_t;
  ent_t sb[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(int d, int p);
    if (d == 0) return p == 0 ? b0.readA : p == 1 ? b0.readB : {31'b0, b0.collision};
    return p == 0 ? b1.readA : p == 1 ? b1.readB : {31'b0, b1.collision};
  endfunction

  function automatic logic rdy(int d);
    return d == 0 ? b0.ready : b1.ready;
  endfunction

  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, obs(sb[i].d, sb[i].p), sb[i].v);
        sb.delete(i);
      end

  task automatic op(int d, logic wa, logic [3:0] aa, logic [31:0] da, logic [3:0] ma,
                    logic wb, logic [3:0] ab, logic [31:0] db, logic [3:0] mb);
    @(negedge clk);
    if (d == 0) begin
      b0.writeEnableA = wa; b0.addressA = aa; b0.writeDataA = da; b0.byteWriteMaskA = ma;
      b0.writeEnableB = wb; b0.addressB = ab; b0.writeDataB = db; b0.byteWriteMaskB = mb;
    end else begin
      b1.writeEnableA = wa; b1.addressA = aa; b1.writeDataA = da; b1.byteWriteMaskA = ma;
      b1.writeEnableB = wb; b1.addressB = ab; b1.writeDataB = db; b1.byteWriteMaskB = mb;
    end
  endtask

  task automatic rd(int d, logic [3:0] aa, logic [3:0] ab);
    op(d, 0, aa, 0, 0, 0, ab, 0, 0);
  endtask

  task automatic expect_rd(int d, int p, string tag, logic [31:0] v);
    sb.push_back('{d, p, cyc + ((d == 1 && p < 2) ? 2 : 1), tag, v});
  endtask

  task automatic drain(int d);
    repeat (3) rd(d, 0, 0);
  endtask

  task automatic reset_state(int d, string tag);
    chk({tag, "_ready"}, {31'b0, rdy(d)}, 0);
    chk({tag, "_readA"}, obs(d, 0), 0);
    chk({tag, "_readB"}, obs(d, 1), 0);
    chk({tag, "_coll"}, obs(d, 2), 0);
  endtask

  // releases reset at the current negedge and counts edges until ready
  task automatic release_wait(int d, int exp_n, logic spam, string tag);
    int n = 0;
    if (d == 0) rst0 = 0; else rst1 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rdy(d)) begin
        n = k;
        break;
      end
      if (spam && k == 5) chk({tag, "_clear_readA"}, b0.readA, 0);
      if (spam) begin
        b0.writeEnableA = 1; b0.addressA = 5; b0.writeDataA = 32'h12345678; b0.byteWriteMaskA = 4'hF;
      end
    end
    if (d == 0) b0.writeEnableA = 0;
    chk({tag, "_ready_cycles"}, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    b0.writeEnableA = 0; b0.writeEnableB = 0; b0.addressA = 0; b0.addressB = 0;
    b0.writeDataA = 0; b0.writeDataB = 0; b0.byteWriteMaskA = 0; b0.byteWriteMaskB = 0;
    b1.writeEnableA = 0; b1.writeEnableB = 0; b1.addressA = 0; b1.addressB = 0;
    b1.writeDataA = 0; b1.writeDataB = 0; b1.byteWriteMaskA = 0; b1.byteWriteMaskB = 0;
    repeat (3) @(negedge clk);
    reset_state(0, "rst0");
    reset_state(1, "rst1");
    release_wait(0, 17, 0, "init0");
    // preload then reset: clear must wipe it and block writes during the walk
    op(0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 5, 0, 0);
    rd(0, 5, 5);
    expect_rd(0, 0, "preload_A", 32'hDEADBEEF);
    drain(0);
    rst0 = 1;
    @(negedge clk);
    reset_state(0, "pulse0");
    release_wait(0, 17, 1, "clear0");
    rd(0, 5, 5);
    expect_rd(0, 0, "cleared5_A", 0);
    expect_rd(0, 1, "cleared5_B", 0);
    op(0, 1, 3, 32'h11223344, 4'hF, 0, 3, 0, 0);
    expect_rd(0, 0, "mask_rf_A0", 0);
    expect_rd(0, 1, "mask_x_B0", 0);
    op(0, 1, 3, 32'hAABBCCDD, 4'h5, 0, 3, 0, 0);
    expect_rd(0, 0, "mask_rf_A1", 32'h11223344);
    rd(0, 0, 3);
    expect_rd(0, 1, "mask_B", 32'h11BB33DD);
    op(0, 1, 7, 32'h1, 4'hF, 0, 7, 0, 0);
    op(0, 1, 7, 32'h2, 4'hF, 0, 7, 0, 0);
    expect_rd(0, 0, "rdw_rf_A", 32'h1);
    expect_rd(0, 1, "rdw_x_B", 32'h1);
    rd(0, 7, 7);
    expect_rd(0, 0, "rdw_after_A", 32'h2);
    op(0, 1, 9, 32'hAAAAAAAA, 4'h3, 1, 9, 32'hBBBBBBBB, 4'h6);
    expect_rd(0, 2, "coll_hi", 1);
    rd(0, 9, 9);
    expect_rd(0, 2, "coll_lo", 0);
    expect_rd(0, 0, "coll_word_A", 32'h00BBAAAA);
    expect_rd(0, 1, "coll_word_B", 32'h00BBAAAA);
    op(0, 1, 10, 32'hAAAAAAAA, 4'h1, 1, 10, 32'hBBBBBBBB, 4'h2);
    expect_rd(0, 2, "nocoll", 0);
    op(0, 1, 9, 32'hFFFFFFFF, 4'h0, 0, 10, 0, 0);
    expect_rd(0, 0, "mask0_A", 32'h00BBAAAA);
    expect_rd(0, 1, "split_B", 32'h0000BBAA);
    rd(0, 9, 9);
    expect_rd(0, 0, "mask0_after", 32'h00BBAAAA);
    drain(0);
    // abort the walk at counter 8 and expect a full restart
    rst0 = 1;
    @(negedge clk);
    rst0 = 0;
    repeat (9) @(negedge clk);
    chk("midclear_ready", {31'b0, b0.ready}, 0);
    rst0 = 1;
    @(negedge clk);
    release_wait(0, 17, 0, "midclear");
    for (int a = 0; a < 16; a++) begin
      rd(0, 4'(a), 4'(15 - a));
      expect_rd(0, 0, $sformatf("zero_A%0d", a), 0);
      expect_rd(0, 1, $sformatf("zero_B%0d", 15 - a), 0);
    end
    drain(0);

    release_wait(1, 1, 0, "init1");
    op(1, 1, 2, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
    expect_rd(1, 0, "wf_A", 32'hCAFEF00D);
    rd(1, 2, 2);
    expect_rd(1, 1, "keep_B_pre", 32'hCAFEF00D);
    drain(1);
    rst1 = 1;
    @(negedge clk);
    reset_state(1, "pulse1");
    release_wait(1, 1, 0, "noclr");
    rd(1, 2, 2);
    expect_rd(1, 0, "keep_A", 32'hCAFEF00D);
    op(1, 1, 7, 32'h1, 4'hF, 0, 7, 0, 0);
    op(1, 1, 7, 32'h2, 4'hF, 0, 7, 0, 0);
    expect_rd(1, 0, "rdw_wf_A", 32'h2);
    expect_rd(1, 1, "rdw_wf_xB", 32'h1);
    op(1, 1, 3, 32'h11223344, 4'hF, 0, 3, 0, 0);
    op(1, 1, 3, 32'hAABBCCDD, 4'h5, 0, 3, 0, 0);
    expect_rd(1, 0, "mask_wf_A", 32'h11BB33DD);
    expect_rd(1, 1, "mask_wf_xB", 32'h11223344);
    drain(1);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jzjpcc_sram_dp.md
# jzjpcc_sram_dp

Parametrised true dual-port synchronous SRAM with per-port byte write masks, selectable same-port read-during-write mode, an optional output register stage, and a post-reset clear sequencer. It is the general memory primitive for instruction and data storage in the pipelined core: fetch uses port A, memory stage uses port B. It infers block RAM. During the clear walk it owns the array and reports not-ready.

## Interface
Parameters:
- ADDR_WIDTH, 12: word address width; depth = 2^ADDR_WIDTH words.
- BYTES, 4: bytes per word; data width DW = 8*BYTES.
- WRITE_FIRST, 0: 0 = read-first (same-port read returns old word); 1 = write-first (returns newly merged word).
- OUT_REG, 0: 1 adds an output register; read latency becomes 2.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = contents retained.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- ready  out  1  high when both ports accept operations.
- collision  out  1  one-cycle pulse when both ports write overlapping bytes of the same address.
- addressA, addressB  in  ADDR_WIDTH  word address per port.
- writeDataA, writeDataB  in  DW  write data per port.
- writeEnableA, writeEnableB  in  1  write strobe per port.
- byteWriteMaskA, byteWriteMaskB  in  BYTES  bit i enables byte i (bits 8i+7:8i).
- readA, readB  out  DW  read data per port.

## Operation
- FSM states: RESET, CLEAR, READY.
  - reset high: state RESET; clear counter 0; ready, collision, readA, readB and the OUT_REG stage are all 0.
  - RESET to CLEAR on the first cycle with reset low, if CLEAR_ON_RESET=1. Otherwise RESET goes to READY.
  - CLEAR: writes all-zero to address counter each cycle, then increments the counter. When counter = 2^ADDR_WIDTH-1 is written, it moves to READY. It does not wrap.
  - READY: terminal until reset.
  - Reset asserted in any state, including mid-CLEAR, returns to RESET and zeroes the counter. A new clear restarts from address 0.
- Outside READY:
  - Port writes are ignored.
  - readA and readB are forced to 0.
  - collision stays 0.
- In READY, each port acts independently:
  - Write: every byte i with writeEnable=1 and mask bit i=1 takes writeData byte i. Unmasked bytes keep their value.
  - Reads happen every cycle, whatever writeEnable is.
  - A write with mask 0 changes nothing. Its read still occurs.
- Same-port read during write:
  - WRITE_FIRST=0: returns the pre-write word.
  - WRITE_FIRST=1: returns the merged word.
- Cross-port read of an address the other port writes in the same cycle always returns the pre-write word, in both modes.
- Both ports write the same address:
  - Port A wins on bytes enabled in both masks.
  - Bytes enabled in only one mask take that port's data.
  - collision pulses high the next cycle if any mask bit overlaps.

## Timing
- Read latency:
  - OUT_REG=0: address at edge N gives data valid after edge N+1.
  - OUT_REG=1: data valid after edge N+2.
- readA and readB hold their value until the next read result. A read is performed every cycle.
- Write takes effect at edge N. A read of that address issued at N+1 returns the new data.
- ready rises:
  - CLEAR_ON_RESET=1: 2^ADDR_WIDTH+1 cycles after the first clock with reset low (one RESET cycle plus the clear walk).
  - CLEAR_ON_RESET=0: 1 cycle after the first clock with reset low.
- An operation presented in the cycle ready first reads 1 is serviced.
- With OUT_REG=1, the output-register stage clears on reset. It passes 0 until real read data arrives.
- collision is registered: 1-cycle latency, 1-cycle width.

## Test plan
Bench uses ADDR_WIDTH=4, BYTES=4 unless noted.
- Reset then clear:
  - Stimulus: preload address 5 = 0xDEADBEEF, pulse reset 1 cycle, release.
  - Required: ready stays 0 for 17 cycles then rises. Reading address 5 returns 0x00000000. Writes attempted during clear have no effect.
- Byte mask:
  - Stimulus: A writes 0x11223344 mask 4'b1111 to address 3. Then A writes 0xAABBCCDD mask 4'b0101 to address 3. Then B reads address 3.
  - Required: readB = 0x11BB33DD one cycle after the address is presented (two with OUT_REG=1).
- Read-during-write mode:
  - Stimulus: address 7 holds 0x1; A writes 0x2 to address 7.
  - Required: readA = 0x1 with WRITE_FIRST=0, 0x2 with WRITE_FIRST=1. readB reading address 7 in the same cycle = 0x1 in both modes.
- Collision:
  - Stimulus: same cycle, A writes 0xAAAAAAAA mask 4'b0011 and B writes 0xBBBBBBBB mask 4'b0110, both to address 9.
  - Required: address 9 = 0x00BBAAAA (from cleared state). collision high exactly one cycle.
- Reset mid-clear:
  - Stimulus: assert reset at clear counter 8, release.
  - Required: ready rises 17 cycles after release. All 16 words read 0.
- CLEAR_ON_RESET=0, OUT_REG=1:
  - Stimulus: write 0xCAFEF00D to address 2, pulse reset, read address 2.
  - Required: ready high 1 cycle after release. readA = 0xCAFEF00D two cycles after the address is presented.
